// File: rtl/sys_ctrl_gen.sv
// System controller: decodes UART command frames, drives the register file and
// the clock-gated ALU, and streams results to the TX FIFO one word at a time.
module sys_ctrl_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FUN_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int OPA_ADDR      = 0,
  parameter int OPB_ADDR      = 1,
  parameter int GATE_DELAY    = 3,
  parameter int TIMEOUT       = 1023
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  input  logic                     FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     ALU_EN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CMD_ERR
);

  localparam int OUT_WORDS = (ALU_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BUF_W     = OUT_WORDS * DATA_WIDTH;
  localparam int CNT_W     = $clog2(OUT_WORDS + 1);
  localparam int TMR_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] OP_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_N = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_OPA, S_OPB, S_FUN, S_GATE, S_ALU_WAIT, S_TX
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [3:0]       gate_cnt;
  logic [BUF_W-1:0] tx_buf;
  logic [CNT_W-1:0] words_left;

  logic timed, timeout_hit, rsp_valid, abort;

  // States waiting on the host or on a responder are guarded by the timer.
  assign timed = state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB,
                               S_FUN, S_RD_WAIT, S_ALU_WAIT};
  assign timeout_hit = (TIMEOUT != 0) && timed && !RX_D_VLD &&
                       (timer == TMR_W'(TIMEOUT - 1));
  assign rsp_valid = (state == S_RD_WAIT && RdData_Valid) ||
                     (state == S_ALU_WAIT && ALU_OUT_VALID);
  assign abort = timeout_hit && !rsp_valid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      timer      <= '0;
      gate_cnt   <= '0;
      tx_buf     <= '0;
      words_left <= '0;
      Address    <= '0;
      WrData     <= '0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      CLK_EN     <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values;
      // strobes default low here and are raised only by the branch that fires.
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
      timer    <= (timed && !RX_D_VLD) ? timer + 1'b1 : '0;

      if (abort) begin
        CMD_ERR <= 1'b1;
        CLK_EN  <= 1'b0;
        timer   <= '0;
        state   <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (RX_D_VLD) begin
            case (RX_P_DATA)
              OP_WR:    state <= S_WR_ADDR;
              OP_RD:    state <= S_RD_ADDR;
              OP_ALU:   state <= S_OPA;
              OP_ALU_N: state <= S_FUN;
              default:  CMD_ERR <= 1'b1;
            endcase
          end
          S_WR_ADDR: if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= S_WR_DATA;
          end
          S_WR_DATA: if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= S_IDLE;
          end
          S_RD_ADDR: if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            RdEn    <= 1'b1;
            state   <= S_RD_WAIT;
          end
          S_RD_WAIT: if (RdData_Valid) begin
            tx_buf     <= BUF_W'(RdData);
            words_left <= CNT_W'(1);
            state      <= S_TX;
          end
          S_OPA: if (RX_D_VLD) begin
            Address <= ADDR_WIDTH'(OPA_ADDR);
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= S_OPB;
          end
          S_OPB: if (RX_D_VLD) begin
            Address <= ADDR_WIDTH'(OPB_ADDR);
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= S_FUN;
          end
          S_FUN: if (RX_D_VLD) begin
            ALU_FUN  <= RX_P_DATA[FUN_WIDTH-1:0];
            CLK_EN   <= 1'b1;
            gate_cnt <= '0;
            state    <= S_GATE;
          end
          // Let the gated clock settle before the enable pulse reaches the ALU.
          S_GATE: begin
            if (gate_cnt == 4'(GATE_DELAY - 1)) begin
              ALU_EN <= 1'b1;
              state  <= S_ALU_WAIT;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
            end
          end
          S_ALU_WAIT: if (ALU_OUT_VALID) begin
            tx_buf     <= BUF_W'(ALU_OUT);
            words_left <= CNT_W'(OUT_WORDS);
            CLK_EN     <= 1'b0;
            state      <= S_TX;
          end
          S_TX: if (!FIFO_FULL) begin
            TX_P_DATA  <= tx_buf[DATA_WIDTH-1:0];
            TX_D_VLD   <= 1'b1;
            tx_buf     <= tx_buf >> DATA_WIDTH;
            words_left <= words_left - 1'b1;
            if (words_left == CNT_W'(1)) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/sys_ctrl_gen.md
Name: sys_ctrl_gen

Overview:
- Parametrised next-generation system controller between the UART RX data synchroniser, the register file, the clock-gated ALU and the TX async FIFO.
- Decodes framed commands: RF write, RF read, ALU with operands, ALU without operands.
- Drives RF and ALU, gates the ALU clock, and pushes results to the FIFO as one or more DATA_WIDTH words, obeying FIFO_FULL backpressure.
- New behaviour: multi-word ALU results, programmable gate-settle delay, frame/response timeout, unknown-opcode error reporting, fully registered outputs with no latches.

Parameters:
- DATA_WIDTH, 8: width of RX bytes, RF data and FIFO words.
- ADDR_WIDTH, 4: RF address width; the address byte is truncated to its LSBs.
- FUN_WIDTH, 4: ALU function width; taken from the LSBs of the FUN byte.
- ALU_OUT_WIDTH, 16: ALU result width; sent as OUT_WORDS = ceil(ALU_OUT_WIDTH/DATA_WIDTH) words.
- OPA_ADDR, 0: RF address for operand A.
- OPB_ADDR, 1: RF address for operand B.
- GATE_DELAY, 3: cycles from CLK_EN rise to the ALU_EN pulse (1..15).
- TIMEOUT, 1023: idle cycles allowed inside a frame or a wait state before abort; 0 disables the timeout.

Ports:
- CLK  in  1  reference clock.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  synchronised RX byte.
- RX_D_VLD  in  1  one-cycle byte-valid pulse.
- RdData  in  DATA_WIDTH  RF read data.
- RdData_Valid  in  1  RF read-data valid.
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full.
- Address  out  ADDR_WIDTH  RF address.
- WrData  out  DATA_WIDTH  RF write data.
- WrEn  out  1  RF write strobe, one cycle.
- RdEn  out  1  RF read strobe, one cycle.
- ALU_FUN  out  FUN_WIDTH  ALU function.
- ALU_EN  out  1  ALU enable pulse.
- CLK_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  FIFO write data.
- TX_D_VLD  out  1  FIFO write-increment pulse.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset: all outputs, all state and the timer go to 0. State goes to IDLE. Reset asserted mid-operation aborts immediately; no FIFO or RF write completes.
- Output timing: every output is a register. Strobes rise the cycle after the RX_D_VLD or valid input that triggers them.

IDLE, on RX_D_VLD with opcode:
- 0xAA -> WR_ADDR.
- 0xBB -> RD_ADDR.
- 0xCC -> OPA.
- 0xDD -> FUN.
- Any other opcode: pulse CMD_ERR and stay in IDLE.

RF write (0xAA):
- WR_ADDR: byte latched into Address -> WR_DATA.
- WR_DATA: byte drives WrData; WrEn pulses one cycle -> IDLE.

RF read (0xBB):
- RD_ADDR: byte latched into Address; RdEn pulses one cycle -> RD_WAIT.
- RD_WAIT: on RdData_Valid, RdData is captured into the TX buffer -> TX with a word count of 1.

ALU with operands (0xCC):
- OPA: byte is written to OPA_ADDR (WrEn pulse) -> OPB.
- OPB: byte is written to OPB_ADDR (WrEn pulse) -> FUN.

FUN and ALU execution:
- FUN: byte LSBs latched into ALU_FUN; CLK_EN set to 1 -> GATE.
- GATE: counts GATE_DELAY cycles, then pulses ALU_EN for exactly one cycle -> ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VALID, ALU_OUT is captured (zero-extended to OUT_WORDS*DATA_WIDTH); CLK_EN cleared -> TX with a word count of OUT_WORDS.

TX:
- Sends words least-significant first.
- In each cycle with FIFO_FULL=0, drives TX_P_DATA = the current word and pulses TX_D_VLD, then advances to the next word.
- While FIFO_FULL=1: TX_D_VLD=0 and the current word is held, never dropped.
- After the last word -> IDLE.

Timeout:
- A timer runs in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, RD_WAIT and ALU_WAIT.
- The timer clears on entry and on every RX_D_VLD.
- On reaching TIMEOUT: pulse CMD_ERR, clear CLK_EN -> IDLE. Partial RF writes already issued stay written.
- TX and GATE never time out.

Other events:
- RX_D_VLD in RD_WAIT, GATE, ALU_WAIT or TX: the byte is ignored.
- RX_D_VLD in the same cycle as the last TX word: the byte is ignored; the controller returns to IDLE.
- A spurious ALU_OUT_VALID or RdData_Valid outside its wait state is ignored.

Test Plan:
1. Frame AA,05,3C -> one WrEn pulse with Address=5 and WrData=0x3C; no TX_D_VLD; state returns to IDLE.
2. Preload RF[2]=0x7E, send BB,02 -> RdEn pulse with Address=2; RdData_Valid -> one TX_D_VLD with TX_P_DATA=0x7E.
3. Frame CC,0x0C,0x0A,0x02 (multiply) -> WrEn to addr 0 then addr 1; CLK_EN rises; ALU_EN pulses exactly 3 cycles later; ALU_OUT=0x0078 -> TX words 0x78 then 0x00; CLK_EN falls.
4. Repeat scenario 3 with FIFO_FULL=1 for 10 cycles during TX -> TX_D_VLD stays 0 and the words are delivered in order, unchanged, after release.
5. Opcode 0x5A -> CMD_ERR pulses once, state stays IDLE; next frame AA,01,11 writes RF[1]=0x11.
6. TIMEOUT=20: send AA,03 then stop -> CMD_ERR pulses 20 cycles after the 03 byte; no WrEn; a new BB frame then works. Also assert reset mid-TX -> all outputs go to 0 immediately.
